// File: rtl/spi_shift_register.sv
// rtl/spi_shift_register.sv - byte-wide SPI transmit/receive shift path
// Loads a byte on send_data, shifts it out on mosi and assembles miso while tip is high.
module spi_shift_register (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       send_data,
  input  logic [7:0] data_mosi,
  input  logic       lsbfe,
  input  logic       tip,
  input  logic       sample_stb,
  input  logic       shift_stb,
  input  logic       miso,
  input  logic       receive_data,
  output logic       mosi,
  output logic [7:0] data_miso,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] tx_reg;
  logic [7:0] rx_reg;
  logic [2:0] tx_cnt;
  logic [3:0] rx_cnt;
  logic       lsbfe_q;

  logic       load_acc;
  logic       rx_full;
  logic       tx_adv;

  // Frame index to register bit position; shared by the TX and RX sides.
  function automatic logic [2:0] bit_map(input logic [2:0] idx, input logic lsb_first);
    return lsb_first ? idx : (3'd7 - idx);
  endfunction

  assign load_acc = send_data && ((state == IDLE) || ((state == ARMED) && !tip));
  assign rx_full  = (rx_cnt == 4'd8);

  // Shift advances only once a sample has landed ahead of it, which makes
  // the leading CPHA=1 shift edge a no-op and keeps bit 0 on the line.
  assign tx_adv   = shift_stb && (rx_cnt > {1'b0, tx_cnt}) && (tx_cnt != 3'd7);

  assign busy     = (state != IDLE);

  always_comb begin
    mosi = 1'b0;
    if (state != IDLE) begin
      mosi = tx_reg[bit_map(tx_cnt, lsbfe_q)];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      tx_reg    <= 8'h00;
      rx_reg    <= 8'h00;
      tx_cnt    <= 3'd0;
      rx_cnt    <= 4'd0;
      lsbfe_q   <= 1'b0;
      data_miso <= 8'h00;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (load_acc) begin
        tx_reg  <= data_mosi;
        lsbfe_q <= lsbfe;
        rx_reg  <= 8'h00;
        tx_cnt  <= 3'd0;
        rx_cnt  <= 4'd0;
        state   <= ARMED;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          ARMED: begin
            if (tip) begin
              state <= SHIFT;
            end
          end
          SHIFT: begin
            // receive_data wins over a simultaneous tip drop.
            if (receive_data) begin
              if (rx_full) begin
                data_miso <= rx_reg;
                rx_valid  <= 1'b1;
              end
              state <= IDLE;
            end else if (!tip) begin
              state <= IDLE;
            end else begin
              if (sample_stb && !rx_full) begin
                rx_reg[bit_map(rx_cnt[2:0], lsbfe_q)] <= miso;
                rx_cnt <= rx_cnt + 4'd1;
              end
              if (tx_adv) begin
                tx_cnt <= tx_cnt + 3'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_shift_register.sv
// tb/tb_spi_shift_register.sv - directed self-checking bench for spi_shift_register
// Linear directed sequence; outputs sampled 1 time unit after the rising edge.
module tb_spi_shift_register;

  logic       PCLK;
  logic       PRESET;
  logic       send_data;
  logic [7:0] data_mosi;
  logic       lsbfe;
  logic       tip;
  logic       sample_stb;
  logic       shift_stb;
  logic       miso;
  logic       receive_data;
  logic       mosi;
  logic [7:0] data_miso;
  logic       rx_valid;
  logic       busy;

  logic       loop_en;
  logic       miso_drv;
  int         passed;
  int         total;

  logic [7:0] tx_b;
  logic [7:0] rx_b;

  assign miso = loop_en ? mosi : miso_drv;

  spi_shift_register dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .send_data    (send_data),
    .data_mosi    (data_mosi),
    .lsbfe        (lsbfe),
    .tip          (tip),
    .sample_stb   (sample_stb),
    .shift_stb    (shift_stb),
    .miso         (miso),
    .receive_data (receive_data),
    .mosi         (mosi),
    .data_miso    (data_miso),
    .rx_valid     (rx_valid),
    .busy         (busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input logic sd, input logic smp, input logic sft, input logic rd);
    send_data    = sd;
    sample_stb   = smp;
    shift_stb    = sft;
    receive_data = rd;
    @(posedge PCLK);
    #1;
    send_data    = 1'b0;
    sample_stb   = 1'b0;
    shift_stb    = 1'b0;
    receive_data = 1'b0;
  endtask

  // Full CPHA=0 loopback frame: sample then shift for each bit, one trailing shift.
  task automatic run_frame(input logic [7:0] d, input logic lsb);
    data_mosi = d;
    lsbfe     = lsb;
    loop_en   = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_busy", {7'd0, busy}, 8'd1);
    tip = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("frame_mosi", {7'd0, mosi}, {7'd0, (lsb ? d[i] : d[7-i])});
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("trail_mosi", {7'd0, mosi}, {7'd0, (lsb ? d[7] : d[0])});
    tip = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("frame_data", data_miso, d);
    chk("frame_rxv", {7'd0, rx_valid}, 8'd1);
    chk("frame_idle", {7'd0, busy}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("frame_rxv_drop", {7'd0, rx_valid}, 8'd0);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    PRESET       = 1'b1;
    send_data    = 1'b0;
    data_mosi    = 8'h00;
    lsbfe        = 1'b0;
    tip          = 1'b0;
    sample_stb   = 1'b0;
    shift_stb    = 1'b0;
    receive_data = 1'b0;
    loop_en      = 1'b0;
    miso_drv     = 1'b0;
    tx_b         = 8'h3C;
    rx_b         = 8'hC3;

    #12;
    chk("rst_mosi", {7'd0, mosi}, 8'd0);
    chk("rst_data", data_miso, 8'h00);
    chk("rst_rxv", {7'd0, rx_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;

    // MSB-first CPHA=0 loopback of A5
    run_frame(8'hA5, 1'b0);

    // Short frame: receive_data after 5 samples
    data_mosi = 8'h5A;
    lsbfe     = 1'b0;
    loop_en   = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tip = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    tip = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("short_data", data_miso, 8'hA5);
    chk("short_rxv", {7'd0, rx_valid}, 8'd0);
    chk("short_busy", {7'd0, busy}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("short_rxv2", {7'd0, rx_valid}, 8'd0);

    // LSB-first CPHA=1: 3C out, C3 in, with a send_data during SHIFT and a 9th sample
    data_mosi = tx_b;
    lsbfe     = 1'b1;
    loop_en   = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("c1_first_mosi", {7'd0, mosi}, {7'd0, tx_b[0]});
    tip = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("c1_mosi", {7'd0, mosi}, {7'd0, tx_b[i]});
      if (i == 4) begin
        data_mosi = 8'hFF;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        data_mosi = 8'h00;
        chk("c1_ignore_load", {7'd0, mosi}, {7'd0, tx_b[i]});
      end
      miso_drv = rx_b[i];
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
    miso_drv = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("c1_hold_mosi", {7'd0, mosi}, {7'd0, tx_b[7]});
    tip = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("c1_data", data_miso, 8'hC3);
    chk("c1_rxv", {7'd0, rx_valid}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("c1_rxv_drop", {7'd0, rx_valid}, 8'd0);

    // Abort after 3 samples, then reload 0F
    data_mosi = 8'h55;
    lsbfe     = 1'b0;
    loop_en   = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tip = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    tip = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_rxv", {7'd0, rx_valid}, 8'd0);
    chk("abort_data", data_miso, 8'hC3);
    chk("abort_mosi", {7'd0, mosi}, 8'd0);
    run_frame(8'h0F, 1'b1);

    // Asynchronous reset mid-frame after 4 samples
    data_mosi = 8'h81;
    lsbfe     = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tip = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("pre_rst_busy", {7'd0, busy}, 8'd1);
    #3;
    PRESET = 1'b1;
    #1;
    chk("arst_mosi", {7'd0, mosi}, 8'd0);
    chk("arst_data", data_miso, 8'h00);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_rxv", {7'd0, rx_valid}, 8'd0);
    #2;
    PRESET = 1'b0;
    tip    = 1'b0;
    @(posedge PCLK);
    #1;
    run_frame(8'h81, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
